// File: rtl/opnd_fetch_pipe_pkg.sv
// Operand kind/size encodings and the size-masking helper shared by the
// operand fetch stage and its hint matcher.
package opnd_fetch_pipe_pkg;

  localparam logic [1:0] OPND_KIND_NONE = 2'd0;
  localparam logic [1:0] OPND_KIND_REG  = 2'd1;
  localparam logic [1:0] OPND_KIND_MEM  = 2'd2;
  localparam logic [1:0] OPND_KIND_IMM  = 2'd3;

  localparam logic [1:0] OPND_SIZE_8  = 2'd0;
  localparam logic [1:0] OPND_SIZE_16 = 2'd1;
  localparam logic [1:0] OPND_SIZE_32 = 2'd2;

  // Encoding 3 is treated as a full 32-bit operand.
  function automatic logic [31:0] size_mask(input logic [1:0] size, input logic [31:0] value);
    logic [31:0] res;
    case (size)
      OPND_SIZE_8:  res = {24'h0, value[7:0]};
      OPND_SIZE_16: res = {16'h0, value[15:0]};
      default:      res = value;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/opnd_fetch_pipe_hint_match.sv
// Priority match of one operand address against the memory hint channels;
// the lowest-index valid read hint with an equal address wins.
module hint_match #(
  parameter int NUM_HINTS = 2
) (
  input  logic [31:0]            addr,
  input  logic [NUM_HINTS-1:0]   hint_valid,
  input  logic [NUM_HINTS-1:0]   hint_is_write,
  input  logic [32*NUM_HINTS-1:0] hint_address,
  input  logic [32*NUM_HINTS-1:0] hint_data,
  output logic [31:0]            data,
  output logic                   hit
);

  // Scan from the top so the lowest matching index is the last assignment.
  always_comb begin
    data = 32'h0;
    hit  = 1'b0;
    for (int h = NUM_HINTS - 1; h >= 0; h--) begin
      if (hint_valid[h] && !hint_is_write[h] && (hint_address[32*h +: 32] == addr)) begin
        data = hint_data[32*h +: 32];
        hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/opnd_fetch_pipe.sv
// Two-stage operand fetch: S1 captures descriptors, registers and hints; the
// resolved operands and per-operand hint misses are registered into S2.
module opnd_fetch_pipe
  import opnd_fetch_pipe_pkg::*;
#(
  parameter int NUM_OPNDS = 3,
  parameter int NUM_HINTS = 2,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*NUM_OPNDS-1:0]  in_kind,
  input  logic [2*NUM_OPNDS-1:0]  in_size,
  input  logic [3*NUM_OPNDS-1:0]  in_regsel,
  input  logic [32*NUM_OPNDS-1:0] in_addr,
  input  logic [32*NUM_OPNDS-1:0] in_imm,
  input  logic [255:0]            regs,
  input  logic [NUM_HINTS-1:0]    hint_valid,
  input  logic [NUM_HINTS-1:0]    hint_is_write,
  input  logic [32*NUM_HINTS-1:0] hint_address,
  input  logic [32*NUM_HINTS-1:0] hint_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*NUM_OPNDS-1:0] out_opnd,
  output logic [NUM_OPNDS-1:0]    out_miss,
  output logic [CNT_W-1:0]        miss_count
);

  logic                    s1_valid;
  logic [2*NUM_OPNDS-1:0]  s1_kind;
  logic [2*NUM_OPNDS-1:0]  s1_size;
  logic [3*NUM_OPNDS-1:0]  s1_regsel;
  logic [32*NUM_OPNDS-1:0] s1_addr;
  logic [32*NUM_OPNDS-1:0] s1_imm;
  logic [255:0]            s1_regs;
  logic [NUM_HINTS-1:0]    s1_hint_valid;
  logic [NUM_HINTS-1:0]    s1_hint_is_write;
  logic [32*NUM_HINTS-1:0] s1_hint_address;
  logic [32*NUM_HINTS-1:0] s1_hint_data;

  logic [32*NUM_OPNDS-1:0] res_opnd;
  logic [NUM_OPNDS-1:0]    res_miss;
  logic                    s1_adv;
  logic                    accept;

  assign s1_adv   = s1_valid && (!out_valid || out_ready);
  assign in_ready = !flush && (!s1_valid || s1_adv);
  assign accept   = in_valid && in_ready;

  // Size 8 with selector 4..7 addresses AH/CH/DH/BH, i.e. bits [15:8] of regs 0..3.
  function automatic logic [31:0] reg_select(input logic [255:0] r, input logic [2:0] sel,
                                             input logic [1:0] size);
    logic [31:0] full;
    logic [31:0] low4;
    logic [31:0] res;
    full = r[32*sel +: 32];
    low4 = r[32*sel[1:0] +: 32];
    case (size)
      OPND_SIZE_8:  res = sel[2] ? {24'h0, low4[15:8]} : {24'h0, low4[7:0]};
      OPND_SIZE_16: res = {16'h0, full[15:0]};
      default:      res = full;
    endcase
    return res;
  endfunction

  for (genvar i = 0; i < NUM_OPNDS; i++) begin : g_opnd
    logic [31:0] mem_data;
    logic        mem_hit;
    logic [31:0] opnd_val;
    logic        miss_val;
    logic [1:0]  kind;
    logic [1:0]  size;

    assign kind = s1_kind[2*i +: 2];
    assign size = s1_size[2*i +: 2];

    hint_match #(.NUM_HINTS(NUM_HINTS)) u_hint_match (
      .addr          (s1_addr[32*i +: 32]),
      .hint_valid    (s1_hint_valid),
      .hint_is_write (s1_hint_is_write),
      .hint_address  (s1_hint_address),
      .hint_data     (s1_hint_data),
      .data          (mem_data),
      .hit           (mem_hit)
    );

    always_comb begin
      opnd_val = 32'h0;
      miss_val = 1'b0;
      case (kind)
        OPND_KIND_REG: opnd_val = reg_select(s1_regs, s1_regsel[3*i +: 3], size);
        OPND_KIND_MEM: begin
          opnd_val = mem_hit ? size_mask(size, mem_data) : 32'h0;
          miss_val = !mem_hit;
        end
        OPND_KIND_IMM: opnd_val = size_mask(size, s1_imm[32*i +: 32]);
        default: ;
      endcase
    end

    assign res_opnd[32*i +: 32] = opnd_val;
    assign res_miss[i]          = miss_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Register and hint state is snapshotted so it belongs to the accepted instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_kind          <= '0;
      s1_size          <= '0;
      s1_regsel        <= '0;
      s1_addr          <= '0;
      s1_imm           <= '0;
      s1_regs          <= '0;
      s1_hint_valid    <= '0;
      s1_hint_is_write <= '0;
      s1_hint_address  <= '0;
      s1_hint_data     <= '0;
    end else if (accept) begin
      s1_kind          <= in_kind;
      s1_size          <= in_size;
      s1_regsel        <= in_regsel;
      s1_addr          <= in_addr;
      s1_imm           <= in_imm;
      s1_regs          <= regs;
      s1_hint_valid    <= hint_valid;
      s1_hint_is_write <= hint_is_write;
      s1_hint_address  <= hint_address;
      s1_hint_data     <= hint_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_opnd  <= '0;
      out_miss  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      out_opnd  <= res_opnd;
      out_miss  <= res_miss;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Counts S2 loads carrying any miss; a transfer coinciding with flush is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miss_count <= '0;
    end else if (!flush && s1_adv && (|res_miss) && (miss_count != {CNT_W{1'b1}})) begin
      miss_count <= miss_count + 1'b1;
    end
  end

endmodule
